// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, flag
// bit positions and the ownership FSM encoding.
package alu_arbiter_pkg;

  localparam int ALU_NREQ = 2;
  localparam int ALU_W    = 16;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU datapath shared by both requesters; arithmetic ops
// are evaluated 17 bits wide so the carry falls out of bit 16.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [3:0]   ctl_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o,
  output logic [3:0]   cond_o
);

  logic [W:0] wide_s;
  logic       ovf_s;

  // Opcode decode; logic and pass ops keep bit W clear so carry reads 0.
  always_comb begin
    wide_s = {1'b0, b_i};
    ovf_s  = 1'b0;
    case (ctl_i)
      OP_ADD: begin
        wide_s = {1'b0, a_i} + {1'b0, b_i};
        ovf_s  = (a_i[W-1] == b_i[W-1]) && (wide_s[W-1] != a_i[W-1]);
      end
      OP_SUB, OP_CMP: begin
        wide_s = {1'b0, a_i} - {1'b0, b_i};
        ovf_s  = (a_i[W-1] != b_i[W-1]) && (wide_s[W-1] != a_i[W-1]);
      end
      OP_AND:  wide_s = {1'b0, a_i & b_i};
      OP_OR:   wide_s = {1'b0, a_i | b_i};
      OP_XOR:  wide_s = {1'b0, a_i ^ b_i};
      default: wide_s = {1'b0, b_i};
    endcase
  end

  assign res_o  = wide_s[W-1:0];
  assign cond_o = pack_flags(wide_s[W-1], (wide_s[W-1:0] == {W{1'b0}}),
                             wide_s[W], ovf_s);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single ALU with a one-deep response
// register; round-robin arbitration with optional per-requester lock.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = ALU_NREQ,
  parameter int W     = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [N_REQ-1:0] req_lock,
  input  logic [3:0]       req0_ctl,
  input  logic [3:0]       req1_ctl,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic [3:0]       rsp_cond,
  output logic [3:0]       flags0,
  output logic [3:0]       flags1
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0] rsp_cond_q, rsp_cond_d;
  logic [3:0] flags0_q, flags0_d;
  logic [3:0] flags1_q, flags1_d;

  logic       can_issue_s;
  logic [1:0] grant_s;
  logic       xfer_s;
  logic       xfer_idx_s;
  logic [3:0] alu_ctl_s;
  logic [W-1:0] alu_a_s, alu_b_s, alu_res_s;
  logic [3:0] alu_cond_s;

  assign can_issue_s = ~rsp_valid_q | rsp_ready;

  // Grant selection; a grant is only raised toward a valid requester, so
  // grant doubles as the transfer vector.
  always_comb begin
    grant_s = 2'b00;
    if (rst || !can_issue_s) begin
      grant_s = 2'b00;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (req_valid[0] && req_valid[1]) begin
            grant_s = last_q ? 2'b01 : 2'b10;
          end else begin
            grant_s = req_valid[1:0];
          end
        end
        ST_OWN0: grant_s = {1'b0, req_valid[0]};
        ST_OWN1: grant_s = {req_valid[1], 1'b0};
        default: grant_s = 2'b00;
      endcase
    end
  end

  assign req_ready  = grant_s;
  assign xfer_s     = |grant_s;
  assign xfer_idx_s = grant_s[1];

  assign alu_ctl_s = xfer_idx_s ? req1_ctl : req0_ctl;
  assign alu_a_s   = xfer_idx_s ? req1_a   : req0_a;
  assign alu_b_s   = xfer_idx_s ? req1_b   : req0_b;

  alu_arbiter_alu #(.W(W)) u_alu (
    .ctl_i  (alu_ctl_s),
    .a_i    (alu_a_s),
    .b_i    (alu_b_s),
    .res_o  (alu_res_s),
    .cond_o (alu_cond_s)
  );

  // Ownership FSM and round-robin pointer next state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (xfer_s) begin
      last_d = xfer_idx_s;
    end else begin
      last_d = last_q;
    end
    case (state_q)
      ST_ARB: begin
        if (xfer_s && req_lock[xfer_idx_s]) begin
          state_d = xfer_idx_s ? ST_OWN1 : ST_OWN0;
        end else begin
          state_d = ST_ARB;
        end
      end
      // Lock held: stay whether or not a transfer happens this cycle.
      ST_OWN0: state_d = req_lock[0] ? ST_OWN0 : ST_ARB;
      ST_OWN1: state_d = req_lock[1] ? ST_OWN1 : ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Response register and per-requester delivered-flag registers.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_cond_d  = rsp_cond_q;
    flags0_d    = flags0_q;
    flags1_d    = flags1_q;
    if (xfer_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = xfer_idx_s;
      rsp_data_d  = alu_res_s;
      rsp_cond_d  = alu_cond_s;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    if (rsp_valid_q && rsp_ready) begin
      if (rsp_id_q) begin
        flags1_d = rsp_cond_q;
      end else begin
        flags0_d = rsp_cond_q;
      end
    end else begin
      flags0_d = flags0_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= {W{1'b0}};
      rsp_cond_q  <= 4'b0000;
      flags0_q    <= 4'b0000;
      flags1_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cond_q  <= rsp_cond_d;
      flags0_q    <= flags0_d;
      flags1_q    <= flags1_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cond  = rsp_cond_q;
  assign flags0    = flags0_q;
  assign flags1    = flags1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_lock;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_cond, flags0, flags1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: owner -1 means free arbitration.
  int          m_owner;
  int          m_last;
  bit          m_rv;
  logic        m_id;
  logic [15:0] m_data;
  logic [3:0]  m_cond;
  logic [3:0]  m_flags [2];
  logic [1:0]  m_er;
  logic [19:0] m_r;
  int          m_k;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_lock(req_lock), .req0_ctl(req0_ctl), .req1_ctl(req1_ctl),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cond(rsp_cond), .flags0(flags0), .flags1(flags1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Returns {N,Z,C,V, result} from plain integer arithmetic.
  function automatic logic [19:0] m_alu(input logic [3:0] op, input int a, input int b);
    int r, sr;
    bit c, v, n, z;
    c = 1'b0; v = 1'b0; r = b;
    case (op)
      4'd0: begin r = a + b; c = (r > 65535); sr = sx(a) + sx(b); v = (sr > 32767) || (sr < -32768); end
      4'd1, 4'd5: begin r = a - b; c = (a < b); sr = sx(a) - sx(b); v = (sr > 32767) || (sr < -32768); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = b;
    endcase
    r = r & 32'h0000FFFF;
    n = (r >= 32768);
    z = (r == 0);
    return {n, z, c, v, r[15:0]};
  endfunction

  function automatic logic [1:0] model_ready();
    if (rst) return 2'b00;
    if (m_rv && !rsp_ready) return 2'b00;
    if (m_owner == 0) return {1'b0, req_valid[0]};
    if (m_owner == 1) return {req_valid[1], 1'b0};
    if (req_valid == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_rv = 1'b0; m_id = 1'b0;
    m_data = 16'h0000; m_cond = 4'h0; m_flags[0] = 4'h0; m_flags[1] = 4'h0;
  endtask

  // Per-cycle compare against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (chk_en) begin
      m_er = model_ready();
      chk("req_ready", req_ready, m_er);
      chk("rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_cond", rsp_cond, m_cond);
        chk("rsp_id", rsp_id, m_id);
      end
      chk("flags0", flags0, m_flags[0]);
      chk("flags1", flags1, m_flags[1]);
      if (rst) begin
        model_reset();
      end else begin
        if (m_rv && rsp_ready) m_flags[m_id] = m_cond;
        if (m_er != 2'b00) begin
          m_k = m_er[1] ? 1 : 0;
          m_r = (m_k == 1) ? m_alu(req1_ctl, req1_a, req1_b) : m_alu(req0_ctl, req0_a, req0_b);
          m_rv = 1'b1; m_id = m_er[1]; m_data = m_r[15:0]; m_cond = m_r[19:16];
          m_last = m_k;
          m_owner = req_lock[m_k] ? m_k : -1;
        end else begin
          if (rsp_ready) m_rv = 1'b0;
          if (m_owner >= 0 && !req_lock[m_owner]) m_owner = -1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; req_valid = 2'b11; req_lock = 2'b00; rsp_ready = 1'b1;
    req0_ctl = OP_ADD; req1_ctl = OP_ADD;
    req0_a = 16'h0001; req0_b = 16'h0002; req1_a = 16'h000A; req1_b = 16'h0014;
    #1 chk("ready_in_reset", req_ready, 2'b00);
    step();
    chk_en = 1'b1;
    step();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 16'h0000);
    chk("reset_flags", {flags0, flags1}, 8'h00);

    // Signed overflow on add.
    rst = 1'b0; req_valid = 2'b01; req0_a = 16'h7FFF; req0_b = 16'h0001;
    #1 chk("add_ready", req_ready, 2'b01);
    step();
    chk("add_data", rsp_data, 16'h8000);
    chk("add_cond", rsp_cond, 4'b1001);
    chk("add_id", rsp_id, 1'b0);

    req_valid = 2'b10; req1_ctl = OP_SUB; req1_a = 16'h0000; req1_b = 16'h0001;
    step();
    chk("sub_data", rsp_data, 16'hFFFF);
    chk("sub_cond", rsp_cond, 4'b1010);
    chk("flags0_after_drain", flags0, 4'b1001);
    req1_ctl = OP_CMP; req1_a = 16'h0005; req1_b = 16'h0005;
    step();
    chk("cmp_data", rsp_data, 16'h0000);
    chk("cmp_cond", rsp_cond, 4'b0100);
    req_valid = 2'b00;
    step();
    chk("flags1_cmp", flags1, 4'b0100);
    chk("drain_no_issue", rsp_valid, 1'b0);

    // Alternating grants without bubbles.
    req0_ctl = OP_ADD; req1_ctl = OP_ADD;
    req0_a = 16'h0001; req0_b = 16'h0002; req1_a = 16'h000A; req1_b = 16'h0014;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_valid", rsp_valid, 1'b1);
      chk("rr_id", rsp_id, i[0]);
    end

    // Lock starves requester 1 for three operations.
    for (int i = 0; i < 3; i++) begin
      req_lock = (i < 2) ? 2'b01 : 2'b00;
      #1 chk("lock_ready", req_ready, 2'b01);
      step();
      chk("lock_id", rsp_id, 1'b0);
      chk("lock_data", rsp_data, 16'h0003);
    end
    req_lock = 2'b00;
    #1 chk("unlock_ready", req_ready, 2'b10);
    step();
    chk("unlock_id", rsp_id, 1'b1);

    // Backpressure holds the response and blocks issue.
    rsp_ready = 1'b0;
    #1 chk("bp_ready", req_ready, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_data", rsp_data, 16'h001E);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_ready_held", req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", req_ready, 2'b01);
    step();
    chk("reissue_valid", rsp_valid, 1'b1);
    chk("reissue_data", rsp_data, 16'h0003);
    chk("flags1_pass", flags1, 4'b0000);

    // Reset while owned with a pending response.
    req_valid = 2'b01; req_lock = 2'b01;
    step();
    req_valid = 2'b11;
    #1 chk("own0_starve", req_ready, 2'b01);
    rst = 1'b1;
    #1 chk("rst_ready", req_ready, 2'b00);
    step();
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_flags", {flags0, flags1}, 8'h00);
    rst = 1'b0; req_lock = 2'b00; req_valid = 2'b10;
    #1 chk("post_rst_req1", req_ready, 2'b10);
    step();
    chk("post_rst_id", rsp_id, 1'b1);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req_lock  = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
      rsp_ready = ($urandom_range(0, 3) != 0);
      req0_ctl  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      req1_ctl  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      req0_a = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      req0_b = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      req1_a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : 16'($urandom);
      step();
    end
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N_REQ, 2, number of requesters; fixed at 2 in this revision.
REQ-002 Parameter: W, 16, operand/result width; fixed at 16.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: req_valid  in  2  per-requester operation valid.
REQ-006 Port: req_ready  out  2  per-requester accept; transfer when valid&ready.
REQ-007 Port: req_lock  in  2  requester holds grant after current transfer.
REQ-008 Port: req0_ctl/req1_ctl  in  4 each  ALU operation code (0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 cmp, other pass-B).
REQ-009 Port: req0_a/req0_b/req1_a/req1_b  in  16 each  operands.
REQ-010 Port: rsp_valid  out  1  response register holds a result.
REQ-011 Port: rsp_ready  in  1  consumer accepts response.
REQ-012 Port: rsp_id  out  1  requester index owning the response.
REQ-013 Port: rsp_data  out  16  ALU result.
REQ-014 Port: rsp_cond  out  4  flags {N,Z,C,V}.
REQ-015 Port: flags0/flags1  out  4 each  last flags delivered to each requester.

Function
REQ-016 One ALU operation is issued per cycle at most; req_ready is one-hot or zero.
REQ-017 Issue allowed only when response register empty or drained same cycle (rsp_valid=0 or rsp_ready=1).
REQ-018 FSM states: ARB, OWN0, OWN1; reset state ARB.
REQ-019 ARB: round-robin; if both valid, grant the requester not granted last; if one valid, grant it.
REQ-020 ARB -> OWNk when requester k transfers with req_lock[k]=1.
REQ-021 OWNk: only requester k may be granted; other requester's req_ready=0 regardless of valid.
REQ-022 OWNk -> ARB when requester k transfers with req_lock[k]=0, or req_lock[k] deasserts while idle.
REQ-023 Latency: operands accepted in cycle T appear on rsp_data/rsp_cond/rsp_id with rsp_valid=1 in cycle T+1.
REQ-024 Response register holds stable while rsp_valid=1 and rsp_ready=0.
REQ-025 Simultaneous drain and issue: register reloads with new result, rsp_valid stays 1, no bubble.
REQ-026 Drain without issue: rsp_valid clears next cycle.
REQ-027 flagsK loads rsp_cond when rsp_valid&rsp_ready and rsp_id=K; otherwise holds.
REQ-028 Arithmetic: add/sub/cmp computed 17-bit; C = bit 16; V = signed overflow; logic/pass ops C=V=0; Z from 16-bit result; N = result bit 15.
REQ-029 cmp (0101) returns subtraction result and flags identically to sub.
REQ-030 Round-robin pointer updates only on an actual transfer, including transfers in OWNk.

Reset
REQ-031 rst=1 at a clock edge: FSM to ARB, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_cond=0, flags0=flags1=0, pointer favours requester 0.
REQ-032 Reset mid-lock or mid-response discards state; no response for pre-reset transfers is produced.
REQ-033 req_ready=0 during the reset cycle.

Structure
REQ-034 Shared package holds ALU opcode constants, flag bit indices (N=3,Z=2,C=1,V=0), and FSM state encoding.
REQ-035 One sub-module: the existing ALU datapath, instantiated once, fed by a granted-operand mux.
REQ-036 Response register and flag registers live in alu_arbiter, not in the sub-module.

Verification
REQ-037 req0 add 0x7FFF+0x0001, rsp_ready=1 -> next cycle rsp_data=0x8000, rsp_cond=1001, rsp_id=0.
REQ-038 req1 sub 0x0000-0x0001 -> rsp_data=0xFFFF, rsp_cond=1010; req1 cmp 0x0005,0x0005 -> rsp_data=0x0000, rsp_cond=0100, flags1=0100 after drain.
REQ-039 Both valid continuously, no lock -> grants alternate 0,1,0,1; back-to-back rsp_valid with no bubbles.
REQ-040 req0 with req_lock=1 for 3 ops while req1 valid -> req1 starved until lock drops; req1 granted next cycle.
REQ-041 rsp_ready=0 for 4 cycles -> rsp_data held, both req_ready=0; rsp_ready=1 -> drain and reissue same cycle.
REQ-042 rst asserted in OWN0 with rsp_valid=1 -> next cycle rsp_valid=0, flags=0, state ARB, req1 grantable.
